// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences CPU read/write strobes into one-cycle synchronous RAM accesses
// Ports: clk, reset_n (async, active low); read/write request levels, addr (MAR), wdata (MDR);
//        rdata to MDR mux, mem_ready completion pulse, busy, sticky overrun/conflict;
//        ram_addr/ram_wdata/ram_re/ram_we/ram_rdata to the RAM; rd_count/wr_count access counters.
// Optional: define MEM_ACCESS_CNT_EN for saturating access counters (tied to 0 otherwise).
module mem_access_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_ready,
   output logic              busy,
   output logic              overrun,
   output logic              conflict,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_re,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);
   typedef enum logic [2:0] {IDLE, RD_STROBE, RD_WAIT, WR_STROBE, DONE} state_t;
   state_t     state;
   logic       read_q, write_q;
   logic [2:0] wait_cnt;
   logic       rd_edge, wr_edge, rd_done;
   assign rd_edge = read & ~read_q;
   assign wr_edge = write & ~write_q;
   // High on the edge that moves a read into DONE; ram_rdata is sampled here so rdata
   // is already valid in the DONE cycle alongside mem_ready.
   assign rd_done = (state == RD_STROBE && RD_LAT == 1) || (state == RD_WAIT && wait_cnt == 3'd1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         wait_cnt  <= 3'd0;
         rdata     <= '0;
         mem_ready <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         conflict  <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_re    <= 1'b0;
         ram_we    <= 1'b0;
      end else begin
         read_q    <= read;
         write_q   <= write;
         ram_re    <= 1'b0;
         ram_we    <= 1'b0;
         mem_ready <= rd_done || state == WR_STROBE;
         if (rd_edge && wr_edge) conflict <= 1'b1;
         if ((rd_edge || wr_edge) && state != IDLE) overrun <= 1'b1;
         if (rd_done) rdata <= ram_rdata;
         case (state)
            IDLE: if (rd_edge ^ wr_edge) begin
               ram_addr <= addr;
               busy     <= 1'b1;
               ram_re   <= rd_edge;
               ram_we   <= wr_edge;
               if (wr_edge) ram_wdata <= wdata;
               state    <= rd_edge ? RD_STROBE : WR_STROBE;
            end
            RD_STROBE: begin
               wait_cnt <= 3'(RD_LAT - 1);
               state    <= rd_done ? DONE : RD_WAIT;
            end
            RD_WAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (rd_done) state <= DONE;
            end
            WR_STROBE: state <= DONE;
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef MEM_ACCESS_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else begin
         if (rd_done && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
         if (state == WR_STROBE && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
   end
`else
   assign rd_count = 16'd0;
   assign wr_count = 16'd0;
`endif
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access sequencer between the CPU control FSM's read/write strobes (with MAR/MDR) and the synchronous main RAM.
- Captures each access request, drives the RAM for exactly one strobe cycle, waits a parameterised latency, then returns read data to the MDR input mux.
- Raises a one-cycle completion pulse and sticky fault flags for protocol misuse.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 32, data word width.
- RD_LAT, 1, RAM read latency in cycles from ram_re to valid ram_rdata (1..7).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- read  input  1  read request level from the control unit.
- write  input  1  write request level from the control unit.
- addr  input  ADDR_W  MAR output.
- wdata  input  DATA_W  MDR output.
- rdata  output  DATA_W  registered read data to the MDR input mux.
- mem_ready  output  1  one-cycle pulse when an access completes.
- busy  output  1  high while an access is in flight.
- overrun  output  1  sticky; a new request edge arrived while busy.
- conflict  output  1  sticky; read and write rose in the same cycle.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_re  output  1  RAM read strobe.
- ram_we  output  1  RAM write strobe.
- ram_rdata  input  DATA_W  RAM read data.
- rd_count  output  16  read counter (see Optional Feature).
- wr_count  output  16  write counter (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-access):
  - All outputs go to 0, FSM goes to IDLE, request-edge registers clear.
  - ram_we/ram_re drop immediately, with no clock needed.
- Request detection:
  - read_q/write_q register the previous levels.
  - A request is the rising edge (read & ~read_q, likewise for write). Held levels never retrigger.
  - addr and wdata are latched on the edge cycle; later MAR/MDR changes have no effect on the access.
- FSM states: IDLE, RD_STROBE, RD_WAIT, WR_STROBE, DONE.
  - IDLE, read edge only: latch, go to RD_STROBE.
  - IDLE, write edge only: latch, go to WR_STROBE.
  - IDLE, both edges together: set conflict, no access, stay in IDLE.
  - RD_STROBE:
    - ram_re=1 and ram_addr=latched addr for exactly one cycle.
    - Load wait counter with RD_LAT-1.
    - Go to RD_WAIT, or straight to DONE when RD_LAT=1.
  - RD_WAIT: decrement the counter; at 0 go to DONE.
  - WR_STROBE: ram_we=1 with ram_addr/ram_wdata = latched values for exactly one cycle, then DONE.
  - DONE:
    - For reads, capture ram_rdata into rdata.
    - mem_ready=1 for this one cycle, then IDLE.
- Latency, counted from the cycle the edge is sampled (cycle 0):
  - Read: ram_re in cycle 1; rdata valid and mem_ready in cycle 1+RD_LAT.
  - Write: ram_we in cycle 1; mem_ready in cycle 2.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Back-to-back: an edge in the DONE cycle is treated as overrun; the earliest accepted edge is in the cycle after DONE.
- Overrun: any request edge while busy sets overrun and is dropped; the in-flight access is unaffected.
- rdata holds its value until the next completed read; writes never change it.
- ram_addr/ram_wdata hold their last driven values when idle; ram_re/ram_we are 0 when idle.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MEM_ACCESS_CNT_EN.
- Defined:
  - rd_count/wr_count increment in the DONE cycle of each completed read/write.
  - They saturate at 16'hFFFF with no wrap, and reset to 0.
- Undefined: no counter registers; rd_count and wr_count are tied to 0.

Test Plan:
1. Reset, then read edge with addr=9'h01A and ram model returning 32'hDEADBEEF, RD_LAT=1 -> ram_re in cycle 1 only; rdata=32'hDEADBEEF and mem_ready pulse in cycle 2; busy in cycles 1-2.
2. Write edge with addr=9'h0FF, wdata=32'h12345678; change addr/wdata to 0 in cycle 1 -> ram_we one cycle in cycle 1 with ram_addr=9'h0FF and ram_wdata=32'h12345678; mem_ready in cycle 2; rdata unchanged.
3. RD_LAT=3, read held high for 6 cycles -> exactly one ram_re pulse, mem_ready in cycle 4, no overrun.
4. read and write rise in the same cycle -> conflict=1, no ram_re/ram_we, busy stays 0. Then a write edge mid-read -> overrun=1, read completes normally, no ram_we.
5. Assert reset_n=0 during RD_WAIT -> ram_re/mem_ready/busy/rdata=0 immediately. After release, the next read completes normally.
6. With MEM_ACCESS_CNT_EN defined: 3 reads and 2 writes -> rd_count=3, wr_count=2. Without the macro, both read 0.
